// File: rtl/capture_pulse_pkg.sv
// Shared types and constants for the capture pulse generator and its delay timer.
package capture_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_DONE  = 2'd2
    } pulse_state_e;

    localparam int PULSE_CNT_W       = 32;
    localparam int TIMER_MAX_DEFAULT = 8000;
    // Shorter hold-off used when frames come from on-chip memory.
    localparam int TIMER_MAX_OCM     = 4000;

endpackage

// File: rtl/delay_timer.sv
// Delay timer: one-cycle timer_out strobe after TIMER_MAX consecutive enabled cycles.
module delay_timer
    import capture_pulse_pkg::*;
#(
    parameter int TIMER_MAX = TIMER_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic timer_ena,
    input  logic timer_rst,
    output logic timer_out
);

    localparam int TIMER_W = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] CNT_LAST = TIMER_W'(TIMER_MAX - 1);

    logic [TIMER_W-1:0] count_q, count_d;
    logic               timer_out_q, timer_out_d;

    // Clear or disable discards any accumulated count.
    always_comb begin
        count_d     = '0;
        timer_out_d = 1'b0;
        if (!timer_rst && timer_ena) begin
            if (count_q == CNT_LAST) begin
                timer_out_d = 1'b1;
            end else begin
                count_d = count_q + TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            timer_out_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            timer_out_q <= timer_out_d;
        end
    end

    assign timer_out = timer_out_q;

endmodule

// File: rtl/capture_pulse_gen.sv
// Capture pulse generator with delay timer. Define PULSE_RETRIGGER_EN to let a
// start during an active pulse reload the width and extend the pulse.
module capture_pulse_gen
    import capture_pulse_pkg::*;
#(
    parameter int TIMER_MAX = TIMER_MAX_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   timer_ena,
    input  logic                   timer_rst,
    output logic                   timer_out,
    input  logic                   start,
    input  logic [PULSE_CNT_W-1:0] pulse_cycle_in,
    output logic                   pulse_out,
    output logic                   end_out
);

    pulse_state_e           state_q;
    logic [PULSE_CNT_W-1:0] cnt_q;
    logic                   pulse_out_q;
    logic                   end_out_q;

    delay_timer #(
        .TIMER_MAX (TIMER_MAX)
    ) u_delay_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .timer_ena (timer_ena),
        .timer_rst (timer_rst),
        .timer_out (timer_out)
    );

    // The down-counter holds the latched width; pulse ends when it is sampled at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pulse_out_q <= 1'b0;
            end_out_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    end_out_q <= 1'b0;
                    if (start) begin
                        cnt_q <= pulse_cycle_in;
                        if (pulse_cycle_in != '0) begin
                            state_q     <= ST_PULSE;
                            pulse_out_q <= 1'b1;
                        end else begin
                            state_q   <= ST_DONE;
                            end_out_q <= 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
`ifdef PULSE_RETRIGGER_EN
                    if (start) begin
                        cnt_q <= pulse_cycle_in;
                        if (pulse_cycle_in == '0) begin
                            state_q     <= ST_DONE;
                            pulse_out_q <= 1'b0;
                            end_out_q   <= 1'b1;
                        end
                    end else begin
`else
                    begin
`endif
                        if (cnt_q == PULSE_CNT_W'(1)) begin
                            state_q     <= ST_DONE;
                            pulse_out_q <= 1'b0;
                            end_out_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - PULSE_CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    end_out_q   <= 1'b0;
                    pulse_out_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    pulse_out_q <= 1'b0;
                    end_out_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_out = pulse_out_q;
    assign end_out   = end_out_q;

endmodule

// File: tb/tb_capture_pulse_gen.sv
// Scoreboard bench for capture_pulse_gen with TIMER_MAX=8; honours PULSE_RETRIGGER_EN.
module tb_capture_pulse_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        timer_ena = 1'b0;
    logic        timer_rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pulse_cycle_in = '0;
    logic        timer_out, pulse_out, end_out;

    typedef struct {
        int len;
        int endc;
    } exp_t;

    exp_t pq[$];
    int   tq[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   plen = 0;
    logic prev_end = 1'b0;

    capture_pulse_gen #(
        .TIMER_MAX (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .timer_ena      (timer_ena),
        .timer_rst      (timer_rst),
        .timer_out      (timer_out),
        .start          (start),
        .pulse_cycle_in (pulse_cycle_in),
        .pulse_out      (pulse_out),
        .end_out        (end_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected end_out lands len+1 cycles after the cycle start is driven.
    task automatic pulse_start(input int w, input int len);
        exp_t e;
        e.len  = len;
        e.endc = cyc + len + 1;
        pq.push_back(e);
        start          = 1'b1;
        pulse_cycle_in = 32'(w);
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int k = 0;
        while (pq.size() != 0 && k < maxc) begin
            tick(1);
            k++;
        end
        check_eq("drain", 64'(pq.size()), 0);
        pq.delete();
        tick(2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            plen     = 0;
            prev_end = 1'b0;
        end else begin
            if (pulse_out) begin
                plen++;
                if (pq.size() == 0) check_eq("unexp_pulse", 1, 0);
            end
            if (end_out) begin
                check_eq("end_single", prev_end, 0);
                check_eq("end_no_pulse", pulse_out, 0);
                if (pq.size() == 0) begin
                    check_eq("unexp_end", 1, 0);
                end else begin
                    e = pq.pop_front();
                    check_eq("pulse_len", plen, e.len);
                    check_eq("end_cyc", cyc, e.endc);
                end
                plen = 0;
            end
            prev_end = end_out;
            if (timer_out) begin
                if (tq.size() == 0) check_eq("unexp_timer", 1, 0);
                else check_eq("timer_cyc", cyc, tq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        tick(3);
        check_eq("rst_pulse", pulse_out, 0);
        check_eq("rst_end", end_out, 0);
        check_eq("rst_timer", timer_out, 0);
        rst_n = 1'b1;

        repeat (4) begin
            tick(25);
            check_eq("idle_pulse", pulse_out, 0);
            check_eq("idle_end", end_out, 0);
            check_eq("idle_timer", timer_out, 0);
        end

        // Continuous enable: strobes every 8 cycles.
        c = cyc;
        timer_ena = 1'b1;
        tq.push_back(c + 8);
        tq.push_back(c + 16);
        tq.push_back(c + 24);
        tick(26);
        timer_ena = 1'b0;
        tick(3);
        check_eq("tmr_cont_q", 64'(tq.size()), 0);

        // Enable dropped after 5 cycles loses the count.
        timer_ena = 1'b1;
        tick(5);
        timer_ena = 1'b0;
        tick(2);
        c = cyc;
        timer_ena = 1'b1;
        tq.push_back(c + 8);
        tick(10);
        timer_ena = 1'b0;
        tick(2);
        check_eq("tmr_reraise_q", 64'(tq.size()), 0);

        // Synchronous clear mid-count restarts from zero.
        c = cyc;
        timer_ena = 1'b1;
        tq.push_back(c + 13);
        tick(4);
        timer_rst = 1'b1;
        tick(1);
        timer_rst = 1'b0;
        tick(12);
        timer_ena = 1'b0;
        tick(2);
        check_eq("tmr_clr_q", 64'(tq.size()), 0);

        pulse_start(5, 5);
        pulse_cycle_in = 32'd100;
        wait_drain(20);

        // Start during end_out cycle is ignored; the following one is accepted.
        pulse_start(2, 2);
        tick(2);
        start = 1'b1;
        pulse_cycle_in = 32'd3;
        tick(1);
        start = 1'b0;
        pulse_start(4, 4);
        wait_drain(20);

        pulse_start(0, 0);
        wait_drain(10);

`ifdef PULSE_RETRIGGER_EN
        pulse_start(10, 7);
`else
        pulse_start(10, 10);
`endif
        tick(2);
        start = 1'b1;
        pulse_cycle_in = 32'd4;
        tick(1);
        start = 1'b0;
        wait_drain(30);

        // Reset asserted asynchronously mid-pulse.
        pulse_start(20, 20);
        tick(6);
        check_eq("pre_rst_pulse", pulse_out, 1);
        rst_n = 1'b0;
        pq.delete();
        #1;
        check_eq("rst_async_pulse", pulse_out, 0);
        check_eq("rst_async_end", end_out, 0);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        pulse_start(3, 3);
        wait_drain(20);

        check_eq("tmr_final_q", 64'(tq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
